// File: rtl/ws2812b_meter_pkg.sv
// ws2812b_meter_pkg: shared count width, band fractions and scheduler states
package ws2812b_meter_pkg;
  localparam int CW = 16;
  localparam logic [7:0] BAND0 = 8'd154;
  localparam logic [7:0] BAND1 = 8'd218;
  typedef logic [CW-1:0] count_t;
  typedef enum logic [1:0] {IDLE, ACCUM, COMPUTE, UPDATE} state_t;
endpackage

// File: rtl/ws2812b_meter_decay.sv
// ws2812b_meter_decay: next on_count, peak_pos and hold_cnt from the frame target
module ws2812b_meter_decay
  import ws2812b_meter_pkg::*;
#(
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY_STEP = 1
) (
  input  count_t target,
  input  count_t on_count,
  input  count_t peak_pos,
  input  count_t hold_cnt,
  input  count_t max_count,
  output count_t on_next,
  output count_t peak_next,
  output count_t hold_next
);
  count_t drop, on_dec, peak_dec, peak_raw;
  always_comb begin
    drop = on_count - target;
    on_dec = target >= on_count ? target : on_count - (drop < count_t'(DECAY_STEP) ? drop : count_t'(DECAY_STEP));
    on_next = on_dec > max_count ? max_count : on_dec;
    peak_dec = peak_pos - count_t'(1);
    peak_raw = target >= peak_pos ? target : hold_cnt != '0 ? peak_pos : peak_dec < on_next ? on_next : peak_dec;
    peak_next = peak_raw > max_count ? max_count : peak_raw;
    hold_next = target >= peak_pos ? count_t'(HOLD_FRAMES) : hold_cnt != '0 ? hold_cnt - count_t'(1) : hold_cnt;
  end
endmodule

// File: rtl/ws2812b_meter_scheduler.sv
// ws2812b_meter_scheduler: frame-synchronised level meter with decay and peak hold
module ws2812b_meter_scheduler
  import ws2812b_meter_pkg::*;
#(
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY_STEP = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [CW-1:0] s_level,
  input  logic          frame_sync,
  input  logic [CW-1:0] max_count,
  output logic          meter_enable,
  output logic [CW-1:0] on_count,
  output logic [CW-1:0] vis_count0,
  output logic [CW-1:0] vis_count1,
  output logic [CW-1:0] vis_count2,
  output logic [CW-1:0] peak_pos,
  output logic          busy
);
  state_t state, state_next;
  count_t acc_max, hold_cnt, target, on_next, peak_next, hold_next;
  ws2812b_meter_decay #(.HOLD_FRAMES(HOLD_FRAMES), .DECAY_STEP(DECAY_STEP)) u_decay (
    .target(target), .on_count(on_count), .peak_pos(peak_pos), .hold_cnt(hold_cnt),
    .max_count(max_count), .on_next(on_next), .peak_next(peak_next), .hold_next(hold_next)
  );
  assign s_ready = state == ACCUM;
  assign busy = state == COMPUTE || state == UPDATE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = !enable ? IDLE :
                 state == IDLE ? ACCUM :
                 state == ACCUM ? (frame_sync ? COMPUTE : ACCUM) :
                 state == COMPUTE ? UPDATE : ACCUM;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      meter_enable <= 1'b0;
      acc_max <= '0;
      hold_cnt <= '0;
      target <= '0;
      on_count <= '0;
      peak_pos <= '0;
      vis_count0 <= '0;
      vis_count1 <= '0;
      vis_count2 <= '0;
    end else begin
      meter_enable <= enable;
      if (!enable) begin
        acc_max <= '0;
        hold_cnt <= '0;
        on_count <= '0;
        peak_pos <= '0;
      end else if (state == ACCUM) begin
        if (s_valid && s_level > acc_max) acc_max <= s_level;
      end else if (state == COMPUTE) begin
        target <= count_t'((32'(acc_max) * 32'(max_count)) >> 16);
        vis_count0 <= count_t'((32'(max_count) * 32'(BAND0)) >> 8);
        vis_count1 <= count_t'((32'(max_count) * 32'(BAND1)) >> 8);
        vis_count2 <= max_count;
      end else if (state == UPDATE) begin
        on_count <= on_next;
        peak_pos <= peak_next;
        hold_cnt <= hold_next;
        acc_max <= '0;
      end
    end
endmodule

// File: tb/tb_ws2812b_meter_scheduler.sv
// tb_ws2812b_meter_scheduler: randomized and directed checks against a frame-level model
module tb_ws2812b_meter_scheduler;
  localparam int HOLD = 30;
  localparam int STEP = 1;
  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, s_valid = 1'b0, frame_sync = 1'b0;
  logic [15:0] s_level = '0, max_count = '0;
  logic s_ready, meter_enable, busy;
  logic [15:0] on_count, vis_count0, vis_count1, vis_count2, peak_pos;
  int n_tests = 0, n_fail = 0;
  int m_on = 0, m_peak = 0, m_hold = 0, m_acc = 0, m_vis0 = 0, m_vis1 = 0, m_vis2 = 0;
  logic rdy_c, rdy_u, busy_c, busy_u;
  ws2812b_meter_scheduler #(.HOLD_FRAMES(HOLD), .DECAY_STEP(STEP)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .s_level(s_level), .frame_sync(frame_sync), .max_count(max_count), .meter_enable(meter_enable),
    .on_count(on_count), .vis_count0(vis_count0), .vis_count1(vis_count1), .vis_count2(vis_count2),
    .peak_pos(peak_pos), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic model_update();
    longint tgt;
    int mx;
    mx = int'(max_count);
    tgt = (longint'(m_acc) * longint'(mx)) >>> 16;
    m_vis0 = (mx * 154) / 256;
    m_vis1 = (mx * 218) / 256;
    m_vis2 = mx;
    if (int'(tgt) >= m_on) m_on = int'(tgt);
    else m_on = m_on - ((m_on - int'(tgt)) < STEP ? (m_on - int'(tgt)) : STEP);
    if (m_on > mx) m_on = mx;
    if (int'(tgt) >= m_peak) begin
      m_peak = int'(tgt);
      m_hold = HOLD;
    end else if (m_hold > 0) m_hold--;
    else begin
      m_peak--;
      if (m_peak < m_on) m_peak = m_on;
    end
    if (m_peak > mx) m_peak = mx;
    m_acc = 0;
  endtask
  task automatic send_sample(input logic [15:0] lvl);
    @(negedge clk);
    s_valid = 1'b1;
    s_level = lvl;
    @(negedge clk);
    s_valid = 1'b0;
    if (int'(lvl) > m_acc) m_acc = int'(lvl);
  endtask
  task automatic do_frame(input logic with_smp, input logic [15:0] lvl, input logic again);
    @(negedge clk);
    frame_sync = 1'b1;
    s_valid = with_smp;
    s_level = lvl;
    @(posedge clk);
    #1;
    rdy_c = s_ready;
    busy_c = busy;
    @(negedge clk);
    frame_sync = again;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    rdy_u = s_ready;
    busy_u = busy;
    @(negedge clk);
    frame_sync = 1'b0;
    @(posedge clk);
    #1;
    if (with_smp && int'(lvl) > m_acc) m_acc = int'(lvl);
    model_update();
  endtask
  task automatic check_model(input string tag);
    n_tests++;
    if (on_count !== 16'(m_on) || peak_pos !== 16'(m_peak)) begin
      n_fail++;
      $display("FAIL %s counts: got on=%0d peak=%0d want on=%0d peak=%0d", tag, on_count, peak_pos, m_on, m_peak);
    end
    n_tests++;
    if (vis_count0 !== 16'(m_vis0) || vis_count1 !== 16'(m_vis1) || vis_count2 !== 16'(m_vis2)) begin
      n_fail++;
      $display("FAIL %s vis: got %0d/%0d/%0d want %0d/%0d/%0d", tag, vis_count0, vis_count1, vis_count2, m_vis0, m_vis1, m_vis2);
    end
  endtask
  task automatic test_reset();
    #12;
    n_tests++;
    if ({s_ready, busy, meter_enable} !== 3'b000 || on_count !== 16'd0 || peak_pos !== 16'd0 ||
        vis_count0 !== 16'd0 || vis_count1 !== 16'd0 || vis_count2 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b busy=%b men=%b on=%0d peak=%0d want all 0", s_ready, busy, meter_enable, on_count, peak_pos);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic test_rise();
    @(negedge clk);
    enable = 1'b1;
    max_count = 16'd60;
    @(negedge clk);
    send_sample(16'h8000);
    do_frame(1'b0, 16'h0, 1'b0);
    n_tests++;
    if (on_count !== 16'd30 || peak_pos !== 16'd30) begin
      n_fail++;
      $display("FAIL rise_counts: got on=%0d peak=%0d want 30/30", on_count, peak_pos);
    end
    n_tests++;
    if (vis_count0 !== 16'd36 || vis_count1 !== 16'd51 || vis_count2 !== 16'd60) begin
      n_fail++;
      $display("FAIL rise_vis: got %0d/%0d/%0d want 36/51/60", vis_count0, vis_count1, vis_count2);
    end
    n_tests++;
    if (meter_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_meter_enable: got %b want 1", meter_enable);
    end
  endtask
  task automatic test_decay_hold();
    int exp_on, exp_peak;
    for (int k = 1; k <= 35; k++) begin
      send_sample(16'h0000);
      do_frame(1'b0, 16'h0, 1'b0);
      exp_on = 30 - k > 0 ? 30 - k : 0;
      exp_peak = k <= 30 ? 30 : 60 - k;
      n_tests++;
      if (on_count !== 16'(exp_on) || peak_pos !== 16'(exp_peak) || peak_pos < on_count) begin
        n_fail++;
        $display("FAIL decay_frame%0d: got on=%0d peak=%0d want on=%0d peak=%0d", k, on_count, peak_pos, exp_on, exp_peak);
      end
    end
    check_model("decay_model");
  endtask
  task automatic test_collision();
    do_frame(1'b1, 16'hFFFF, 1'b0);
    n_tests++;
    if (on_count !== 16'd59) begin
      n_fail++;
      $display("FAIL collision_on: got %0d want 59", on_count);
    end
    n_tests++;
    if ({rdy_c, rdy_u, busy_c, busy_u} !== 4'b0011) begin
      n_fail++;
      $display("FAIL collision_handshake: got rdy=%b%b busy=%b%b want rdy=00 busy=11", rdy_c, rdy_u, busy_c, busy_u);
    end
    check_model("collision_model");
  endtask
  task automatic test_ignore();
    do_frame(1'b0, 16'h0, 1'b1);
    @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_busy: got %b want 0", busy);
    end
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (on_count !== 16'd58 || on_count !== 16'(m_on)) begin
      n_fail++;
      $display("FAIL ignore_single_update: got on=%0d want 58", on_count);
    end
  endtask
  task automatic test_random();
    int n;
    for (int f = 0; f < 25; f++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) max_count = 16'($urandom_range(1, 400));
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) send_sample(16'($urandom));
      do_frame(1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
      check_model($sformatf("random%0d", f));
      n_tests++;
      if (on_count > max_count || peak_pos > max_count) begin
        n_fail++;
        $display("FAIL random%0d_bound: got on=%0d peak=%0d max=%0d want both <= max", f, on_count, peak_pos, max_count);
      end
    end
  endtask
  task automatic test_zero_count();
    @(negedge clk);
    max_count = 16'd0;
    for (int f = 0; f < 3; f++) begin
      send_sample(16'($urandom));
      do_frame(1'b1, 16'($urandom), 1'b0);
      n_tests++;
      if (on_count !== 16'd0 || peak_pos !== 16'd0 || vis_count0 !== 16'd0 || vis_count1 !== 16'd0 || vis_count2 !== 16'd0) begin
        n_fail++;
        $display("FAIL zero_count%0d: got on=%0d peak=%0d vis=%0d/%0d/%0d want all 0", f, on_count, peak_pos, vis_count0, vis_count1, vis_count2);
      end
    end
  endtask
  task automatic test_disable();
    @(negedge clk);
    max_count = 16'd100;
    send_sample(16'hC000);
    do_frame(1'b0, 16'h0, 1'b0);
    send_sample(16'h4000);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (on_count !== 16'd0 || peak_pos !== 16'd0 || busy !== 1'b0 || s_ready !== 1'b0 || meter_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_clear: got on=%0d peak=%0d busy=%b rdy=%b men=%b want 0", on_count, peak_pos, busy, s_ready, meter_enable);
    end
    n_tests++;
    if (vis_count0 !== 16'(m_vis0) || vis_count1 !== 16'(m_vis1) || vis_count2 !== 16'(m_vis2)) begin
      n_fail++;
      $display("FAIL disable_vis_hold: got %0d/%0d/%0d want %0d/%0d/%0d", vis_count0, vis_count1, vis_count2, m_vis0, m_vis1, m_vis2);
    end
    m_on = 0;
    m_peak = 0;
    m_hold = 0;
    m_acc = 0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    do_frame(1'b0, 16'h0, 1'b0);
    check_model("disable_acc_cleared");
  endtask
  task automatic test_reset_mid_update();
    send_sample(16'h8000);
    do_frame(1'b0, 16'h0, 1'b0);
    @(negedge clk);
    frame_sync = 1'b1;
    s_valid = 1'b1;
    s_level = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    frame_sync = 1'b0;
    s_valid = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (on_count !== 16'd0 || peak_pos !== 16'd0 || vis_count0 !== 16'd0 || vis_count1 !== 16'd0 || vis_count2 !== 16'd0 ||
        {busy, s_ready, meter_enable} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: got on=%0d peak=%0d vis0=%0d busy=%b rdy=%b men=%b want all 0", on_count, peak_pos, vis_count0, busy, s_ready, meter_enable);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (on_count !== 16'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_update: got on=%0d busy=%b want 0/0", on_count, busy);
    end
    m_on = 0;
    m_peak = 0;
    m_hold = 0;
    m_acc = 0;
    m_vis0 = 0;
    m_vis1 = 0;
    m_vis2 = 0;
    @(negedge clk);
    reset_n = 1'b1;
    send_sample(16'hA000);
    do_frame(1'b0, 16'h0, 1'b0);
    check_model("resume_after_reset");
  endtask
  initial begin
    test_reset();
    test_rise();
    test_decay_hold();
    test_collision();
    test_ignore();
    test_random();
    test_zero_count();
    test_disable();
    test_reset_mid_update();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
